// File: rtl/rt_config_sequencer_if.sv
// Config-entry handshake between the host/config network and the sequencer.
interface rt_config_sequencer_if #(
  parameter int FLOW_BITS = 8,
  parameter int RT_WIDTH  = 5
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [FLOW_BITS-1:0] cfg_flowID;
  logic [RT_WIDTH-1:0]  cfg_entry;

  modport master (output cfg_valid, output cfg_flowID, output cfg_entry, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_flowID, input cfg_entry, output cfg_ready);
endinterface

// File: rtl/rt_config_sequencer.sv
// Runtime routing-table reprogramming controller: drain the router, switch it
// off, stream table writes through PROG/rt_*, settle, then re-enable.
module rt_config_sequencer #(
  parameter int FLOW_BITS     = 8,
  parameter int RT_WIDTH      = 5,
  parameter int QUIET_BITS    = 14,
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FLOW_BITS:0]    num_entries,
  input  logic                  abort,
  rt_config_sequencer_if.slave  cfg,
  input  logic [QUIET_BITS-1:0] buf_empty,
  output logic                  ON,
  output logic                  PROG,
  output logic [FLOW_BITS-1:0]  rt_flowID,
  output logic [RT_WIDTH-1:0]   rt_entry,
  output logic                  hold_inject,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [QW-1:0]      QUIET_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [FLOW_BITS:0] REM_ONE     = (FLOW_BITS + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PROGRAM,
    ST_SETTLE
  } state_t;

  state_t               r_state;
  logic [FLOW_BITS:0]   r_remaining;
  logic [QW-1:0]        r_quiet;
  logic [SW-1:0]        r_settle;
  logic                 r_on;
  logic                 r_prog;
  logic [FLOW_BITS-1:0] r_flow;
  logic [RT_WIDTH-1:0]  r_entry;
  logic                 r_hold;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;

  logic w_quiet;
  logic w_ready;
  logic w_hs;

  assign w_quiet = &buf_empty;
  // Abort suppresses ready so a coincident entry is never consumed.
  assign w_ready = (r_state == ST_PROGRAM) && !abort;
  assign w_hs    = cfg.cfg_valid && w_ready;

  assign cfg.cfg_ready = w_ready;
  assign ON            = r_on;
  assign PROG          = r_prog;
  assign rt_flowID     = r_flow;
  assign rt_entry      = r_entry;
  assign hold_inject   = r_hold;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_quiet     <= '0;
      r_settle    <= '0;
      r_on        <= 1'b1;
      r_prog      <= 1'b0;
      r_flow      <= '0;
      r_entry     <= '0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state     <= ST_IDLE;
        r_remaining <= '0;
        r_quiet     <= '0;
        r_settle    <= '0;
        r_on        <= 1'b1;
        r_prog      <= 1'b0;
        r_hold      <= 1'b0;
        r_busy      <= 1'b0;
        r_aborted   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (num_entries == '0) begin
                r_done <= 1'b1;
              end else begin
                r_remaining <= num_entries;
                r_quiet     <= '0;
                r_settle    <= '0;
                r_hold      <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (w_quiet) begin
              if (r_quiet == QUIET_LAST) begin
                r_on    <= 1'b0;
                r_quiet <= '0;
                r_state <= ST_PROGRAM;
              end else begin
                r_quiet <= r_quiet + QW'(1);
              end
            end else begin
              r_quiet <= '0;
            end
          end
          ST_PROGRAM: begin
            if (w_hs) begin
              r_prog      <= 1'b1;
              r_flow      <= cfg.cfg_flowID;
              r_entry     <= cfg.cfg_entry;
              r_remaining <= r_remaining - REM_ONE;
              if (r_remaining == REM_ONE) begin
                r_settle <= '0;
                r_state  <= ST_SETTLE;
              end
            end else begin
              r_prog <= 1'b0;
            end
          end
          ST_SETTLE: begin
            r_prog <= 1'b0;
            if (r_settle == SETTLE_LAST) begin
              r_settle <= '0;
              r_on     <= 1'b1;
              r_hold   <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= ST_IDLE;
            end else begin
              r_settle <= r_settle + SW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(r_done && r_aborted));
      assert (!((r_state == ST_IDLE) && !r_on));
    end
  end
`endif

endmodule

// File: tb/tb_rt_config_sequencer.sv
// Scoreboarded bench for rt_config_sequencer: expected table writes are queued
// at acceptance and matched against PROG pulses; event cycles are timed.
module tb_rt_config_sequencer;
  localparam int FB = 8;
  localparam int RW = 5;
  localparam int QB = 14;
  localparam int QC = 4;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FB:0]   num_entries = '0;
  logic [QB-1:0] buf_empty = '1;
  logic          ON, PROG, hold_inject, busy, done, aborted;
  logic [FB-1:0] rt_flowID;
  logic [RW-1:0] rt_entry;

  rt_config_sequencer_if #(.FLOW_BITS(FB), .RT_WIDTH(RW)) cfg_if ();

  rt_config_sequencer #(
    .FLOW_BITS(FB), .RT_WIDTH(RW), .QUIET_BITS(QB),
    .QUIET_CYCLES(QC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .num_entries(num_entries),
    .abort(abort), .cfg(cfg_if), .buf_empty(buf_empty),
    .ON(ON), .PROG(PROG), .rt_flowID(rt_flowID), .rt_entry(rt_entry),
    .hold_inject(hold_inject), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [FB-1:0] f;
    logic [RW-1:0] e;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_w;

  int n_checks = 0;
  int n_errors = 0;

  int prog_count = 0, last_prog = -1, prev_prog = -1;
  int on_fall = -1, on_fall_count = 0, on_rise = -1;
  int done_count = 0, done_cyc = -1, abort_count = 0, abort_cyc = -1;
  logic on_d = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (PROG) begin
        check("prog_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check("rt_flowID", 32'(rt_flowID), 32'(mon_w.f));
          check("rt_entry", 32'(rt_entry), 32'(mon_w.e));
        end
        prev_prog = last_prog;
        last_prog = cyc;
        prog_count++;
      end
      if (on_d && !ON) begin on_fall = cyc; on_fall_count++; end
      if (!on_d && ON) on_rise = cyc;
      if (done) begin done_cyc = cyc; done_count++; end
      if (aborted) begin abort_cyc = cyc; abort_count++; end
      if (done || aborted) check("done_aborted_excl", 32'(done && aborted), 32'd0);
    end
    on_d = ON;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, output int s);
    start = 1'b1;
    num_entries = (FB + 1)'(n);
    s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [FB-1:0] f, input logic [RW-1:0] e);
    int k;
    wr_t w;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_flowID = f;
    cfg_if.cfg_entry  = e;
    @(negedge clk);
    k = 0;
    while (!cfg_if.cfg_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", 32'(cfg_if.cfg_ready), 32'd1);
    if (cfg_if.cfg_ready) begin
      w.f = f;
      w.e = e;
      exp_q.push_back(w);
    end
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (done_count == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_count - base), 32'd1);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int s, e, run, bp, bd, ba, bf;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_flowID = '0;
    cfg_if.cfg_entry  = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("reset_vals", 32'({ON, PROG, busy, hold_inject, done, aborted, cfg_if.cfg_ready}), 32'b1000000);
    check("reset_rt", 32'({rt_flowID, rt_entry}), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", 32'({ON, PROG, busy, cfg_if.cfg_ready}), 32'b1000);
    end
    tick();

    // Three back-to-back entries with an already-empty router
    bp = prog_count; bd = done_count;
    do_start(3, s);
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(hold_inject), 32'd1);
    send(8'h05, 5'h11);
    send(8'h06, 5'h02);
    send(8'h07, 5'h1F);
    wait_done(bd, 100);
    check("on_fall_cyc", 32'(on_fall), 32'(s + QC));
    check("prog_count3", 32'(prog_count - bp), 32'd3);
    check("last_prog3", 32'(last_prog), 32'(s + QC + 3));
    check("prog_b2b", 32'(last_prog - prev_prog), 32'd1);
    check("done_cyc", 32'(done_cyc), 32'(last_prog + SC));
    check("on_rise_cyc", 32'(on_rise), 32'(last_prog + SC));
    check("idle_after_done", 32'({ON, busy, hold_inject}), 32'b100);

    // Drain with bit 7 dropping every third cycle
    bd = done_count;
    do_start(1, s);
    run = 0;
    for (int i = 0; i < 20; i++) begin
      buf_empty = '1;
      buf_empty[7] = ((i % 3) != 2);
      run = buf_empty[7] ? run + 1 : 0;
      @(negedge clk);
      check("drain_on_hold", 32'({ON, hold_inject}), 32'b11);
      tick();
    end
    buf_empty = '1;
    e = cyc;
    send(8'h2A, 5'h0C);
    wait_done(bd, 100);
    check("drain_on_fall", 32'(on_fall), 32'(e + (QC - run)));

    // Gapped valid pattern 1,0,0,1
    bp = prog_count; bd = done_count;
    do_start(2, s);
    send(8'h33, 5'h15);
    tick();
    @(negedge clk);
    check("gap_prog_low", 32'(PROG), 32'd0);
    check("gap_hold", 32'({rt_flowID, rt_entry}), 32'({8'h33, 5'h15}));
    tick();
    check("gap_hold2", 32'(rt_flowID), 32'h33);
    send(8'h44, 5'h0A);
    wait_done(bd, 100);
    check("gap_prog_count", 32'(prog_count - bp), 32'd2);
    check("gap_spacing", 32'(last_prog - prev_prog), 32'd3);

    // Abort coincident with the second handshake of four
    bp = prog_count; bd = done_count; ba = abort_count;
    do_start(4, s);
    send(8'h50, 5'h01);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_flowID = 8'h51;
    cfg_if.cfg_entry  = 5'h02;
    abort = 1'b1;
    @(negedge clk);
    check("ready_abort", 32'(cfg_if.cfg_ready), 32'd0);
    tick();
    abort = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("abort_outs", 32'({aborted, ON, busy, hold_inject, PROG}), 32'b11000);
    tick();
    check("abort_pulse_once", 32'(aborted), 32'd0);
    repeat (4) tick();
    check("abort_prog_count", 32'(prog_count - bp), 32'd1);
    check("abort_count", 32'(abort_count - ba), 32'd1);
    check("abort_no_done", 32'(done_count - bd), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    bd = done_count;
    do_start(1, s);
    check("restart_busy", 32'(busy), 32'd1);
    send(8'h60, 5'h1E);
    wait_done(bd, 100);

    // Zero-entry start
    bf = on_fall_count;
    do_start(0, s);
    check("zero_done", 32'({done, busy, ON, hold_inject}), 32'b1010);
    tick();
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_on_kept", 32'(on_fall_count - bf), 32'd0);

    // Asynchronous reset mid-PROGRAM
    do_start(2, s);
    send(8'h70, 5'h07);
    @(negedge clk);
    #1;
    check("pre_reset", 32'({PROG, ON}), 32'b10);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({ON, PROG, busy, hold_inject, cfg_if.cfg_ready}), 32'b10000);
    check("async_reset_rt", 32'({rt_flowID, rt_entry}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 32'({ON, busy, cfg_if.cfg_ready}), 32'b100);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
